// File: rtl/div_unit_if.sv
// Request/response bundle between a client and the div_unit divider.
// The client drives start/a/b; the divider returns hi/lo plus its status flags.
interface div_unit_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// 32-bit signed restoring divider (MIPS DIV semantics), one quotient bit per clock.
// Define DIV_ZERO_EXC_EN to flag and short-circuit division by zero.
module div_unit (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic [31:0] rem;
    logic [5:0]  count;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        fit;
    logic [31:0] rem_next;
    logic [31:0] quo_next;

    // Magnitudes are unsigned, so -2^31 maps cleanly onto 0x80000000.
    assign mag_a = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign mag_b = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

    // One restoring step: the 33-bit trial never overflows because rem < divisor <= 2^31.
    always_comb begin
        trial    = {rem, quo[31]};
        diff     = trial - {1'b0, divisor};
        fit      = ~diff[32];
        rem_next = fit ? diff[31:0] : trial[31:0];
        quo_next = {quo[30:0], fit};
    end

`ifdef DIV_ZERO_EXC_EN
    logic div_zero_q;
    assign bus.div_zero = div_zero_q;
`else
    assign bus.div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            quo     <= 32'd0;
            divisor <= 32'd0;
            rem     <= 32'd0;
            count   <= 6'd0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            div_zero_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
`ifdef DIV_ZERO_EXC_EN
                        if (bus.b == 32'd0) begin
                            busy_q     <= 1'b1;
                            done_q     <= 1'b1;
                            div_zero_q <= 1'b1;
                            state      <= FINISH;
                        end else
`endif
                        begin
                            quo     <= mag_a;
                            divisor <= mag_b;
                            sign_a  <= bus.a[31];
                            sign_b  <= bus.b[31];
                            rem     <= 32'd0;
                            count   <= 6'd0;
                            busy_q  <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    quo   <= quo_next;
                    rem   <= rem_next;
                    count <= count + 6'd1;
                    // The 32nd step writes the signed results directly from the step outputs.
                    if (count == 6'd31) begin
                        lo_q   <= (sign_a ^ sign_b) ? (~quo_next + 32'd1) : quo_next;
                        hi_q   <= sign_a ? (~rem_next + 32'd1) : rem_next;
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end
                end
                FINISH: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL: one clock; reset is synchronous and active-high.
REQ-002 SHALL: clk  input  1  rising-edge system clock.
REQ-003 SHALL: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL: a  input  32  signed dividend (rs operand).
REQ-006 SHALL: b  input  32  signed divisor (rt operand).
REQ-007 SHALL: hi  output  32  remainder, registered; feeds the HI path of the register write-back mux.
REQ-008 SHALL: lo  output  32  quotient, registered; feeds the LO path of the register write-back mux.
REQ-009 SHALL: busy  output  1  high while a division is in progress.
REQ-010 SHALL: done  output  1  one-cycle pulse when hi/lo are final.
REQ-011 SHALL: div_zero  output  1  one-cycle pulse on divide-by-zero; see Configuration.

Function
REQ-012 SHALL: FSM states are IDLE, RUN and FINISH, encoded as registered state.
REQ-013 SHALL: in IDLE with start=1 at edge N: latch |a|, |b|, sign(a), sign(b); clear the 6-bit iteration counter and partial remainder; go to RUN.
REQ-014 SHALL: RUN performs one restoring shift-subtract step per edge, MSB of |a| first, for exactly 32 steps.
REQ-015 SHALL: at edge N+32, apply signs and write hi/lo: quotient negated iff sign(a) XOR sign(b); remainder negated iff sign(a); go to FINISH.
REQ-016 SHALL: FINISH lasts one cycle with done=1, then IDLE; total latency is start sampled at edge N -> done high in the cycle after edge N+32.
REQ-017 SHALL: busy=1 in RUN and FINISH; busy=0 in IDLE.
REQ-018 SHALL: start is ignored while busy=1; operand inputs are don't-care after edge N.
REQ-019 SHALL: start asserted in the cycle after FINISH (IDLE) is accepted normally, allowing back-to-back operations.
REQ-020 SHALL: hi/lo hold their last result until the next write; they do not change during RUN.
REQ-021 SHALL: results follow the MIPS DIV convention: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-022 SHALL: -2^31 / -1 produces lo=0x80000000 and hi=0x00000000 (wrap, no flag).
REQ-023 SHALL: |a| of -2^31 is 0x80000000, treated as unsigned magnitude (33-bit internal remainder path).

Reset
REQ-024 SHALL: reset=1 at any edge forces IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
REQ-025 SHALL: reset during RUN aborts the operation; no done pulse is issued and hi/lo become 0.
REQ-026 SHALL: reset has priority over start at the same edge.

Configuration
REQ-027 SHALL: macro DIV_ZERO_EXC_EN controls divide-by-zero detection.
REQ-028 SHALL: with DIV_ZERO_EXC_EN defined, start with b==0 in IDLE skips RUN and goes to FINISH at edge N.
  - done=1 and div_zero=1 for that single cycle.
  - hi/lo are left unchanged.
REQ-029 SHALL: without DIV_ZERO_EXC_EN, div_zero is tied 0 and b==0 runs the full 32 steps.
  - a>=0 gives lo=0xFFFFFFFF, hi=a.
  - a<0 gives lo=0x00000001, hi=a.

Verification
REQ-030 SHALL: a=7, b=2, start at edge N -> done in cycle after N+32; lo=3, hi=1; busy high for 33 cycles.
REQ-031 SHALL: a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then immediately a=100, b=-7 -> lo=0xFFFFFFF2, hi=2.
REQ-032 SHALL: a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL: a=5, b=0 -> with macro: done+div_zero in cycle after edge N, hi/lo keep their prior values; without macro: after 33 cycles lo=0xFFFFFFFF, hi=5, div_zero=0.
REQ-034 SHALL: start with a=9, b=3, then reset at edge N+10 -> busy=0 next cycle, hi=lo=0, no done pulse; a new start 1 cycle later completes with lo=3, hi=0.
REQ-035 SHALL: start pulsed again at N+5 with a=1, b=1 during a 9/3 run -> ignored; result lo=3, hi=0 and exactly one done pulse.
